// File: rtl/branch_resolve_predictor_if.sv
// ============================================================================
// Module      : branch_resolve_predictor_if
// Description : Fetch-lookup and execute-resolve bundle for the branch
//               resolve/predict block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface branch_resolve_predictor_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 16
);
    logic [XLEN-1:0]   i_pred_pc;
    logic              o_pred_taken;
    logic              i_res_valid;
    logic [XLEN-1:0]   i_res_pc;
    logic              i_res_pred_taken;
    logic              i_branch;
    logic              i_jalr;
    logic              i_zero;
    logic              i_neg;
    logic              i_negU;
    logic [2:0]        i_funct3;
    logic [1:0]        o_prePCSrc;
    logic              o_mispredict;
    logic              o_illegal;
    logic [PERF_W-1:0] o_br_count;
    logic [PERF_W-1:0] o_mispred_count;

    modport master (
        output i_pred_pc, i_res_valid, i_res_pc, i_res_pred_taken, i_branch,
               i_jalr, i_zero, i_neg, i_negU, i_funct3,
        input  o_pred_taken, o_prePCSrc, o_mispredict, o_illegal,
               o_br_count, o_mispred_count
    );

    modport slave (
        input  i_pred_pc, i_res_valid, i_res_pc, i_res_pred_taken, i_branch,
               i_jalr, i_zero, i_neg, i_negU, i_funct3,
        output o_pred_taken, o_prePCSrc, o_mispredict, o_illegal,
               o_br_count, o_mispred_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_predictor.sv
// ============================================================================
// Module      : branch_resolve_predictor
// Description : Branch condition resolve plus bimodal BHT predictor with
//               registered mispredict/illegal pulses and perf counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_resolve_predictor #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int PERF_W    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    branch_resolve_predictor_if.slave bus
);

    localparam int               c_IDX_W   = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] c_RST_VAL = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0]   bht_q [BHT_DEPTH];
    logic [CNT_W-1:0]   bht_d [BHT_DEPTH];
    logic [PERF_W-1:0]  br_count_q;
    logic [PERF_W-1:0]  br_count_d;
    logic [PERF_W-1:0]  mispred_count_q;
    logic [PERF_W-1:0]  mispred_count_d;
    logic               mispredict_q;
    logic               mispredict_d;
    logic               illegal_q;
    logic               illegal_d;

    logic               w_taken;
    logic               w_legal;
    logic               w_res_ev;
    logic               w_ill_ev;
    logic [c_IDX_W-1:0] w_pred_idx;
    logic [c_IDX_W-1:0] w_res_idx;
    logic               w_unused;

    assign w_pred_idx = bus.i_pred_pc[c_IDX_W+1:2];
    assign w_res_idx  = bus.i_res_pc[c_IDX_W+1:2];
    assign w_unused   = ^{bus.i_pred_pc, bus.i_res_pc};

    // Reads the registered table only; same-cycle updates appear next cycle.
    assign bus.o_pred_taken = bht_q[w_pred_idx][CNT_W-1];

    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        case (bus.i_funct3)
            3'b000:  w_taken = bus.i_zero;
            3'b001:  w_taken = ~bus.i_zero;
            3'b100:  w_taken = bus.i_neg;
            3'b101:  w_taken = ~bus.i_neg;
            3'b110:  w_taken = bus.i_negU;
            3'b111:  w_taken = ~bus.i_negU;
            default: w_legal = 1'b0;
        endcase
    end

    assign bus.o_prePCSrc = {bus.i_jalr, bus.i_branch & w_taken};

    assign w_res_ev = bus.i_res_valid & bus.i_branch & w_legal;
    assign w_ill_ev = bus.i_res_valid & bus.i_branch & ~w_legal;

    always_comb begin
        bht_d           = bht_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        mispredict_d    = 1'b0;
        illegal_d       = w_ill_ev;
        if (w_res_ev) begin
            if (w_taken) begin
                if (bht_q[w_res_idx] != c_CNT_MAX) begin
                    bht_d[w_res_idx] = bht_q[w_res_idx] + CNT_W'(1);
                end
            end else if (bht_q[w_res_idx] != '0) begin
                bht_d[w_res_idx] = bht_q[w_res_idx] - CNT_W'(1);
            end
            if (br_count_q != '1) begin
                br_count_d = br_count_q + PERF_W'(1);
            end
            if (w_taken != bus.i_res_pred_taken) begin
                mispredict_d = 1'b1;
                if (mispred_count_q != '1) begin
                    mispred_count_d = mispred_count_q + PERF_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= c_RST_VAL;
            end
            br_count_q      <= '0;
            mispred_count_q <= '0;
            mispredict_q    <= 1'b0;
            illegal_q       <= 1'b0;
        end else begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= bht_d[i];
            end
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
            mispredict_q    <= mispredict_d;
            illegal_q       <= illegal_d;
        end
    end

    assign bus.o_mispredict    = mispredict_q;
    assign bus.o_illegal       = illegal_q;
    assign bus.o_br_count      = br_count_q;
    assign bus.o_mispred_count = mispred_count_q;

endmodule

`default_nettype wire
